mole_scheduler: RTL

//   Round sequencer for the whack-a-mole game. Requests a fresh pattern from the
//   rng block, shows it on the 18 red LEDs for a fixed window, and scores switch hits

---
 rtl/mole_scheduler.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/mole_scheduler.sv
// Round sequencer for the whack-a-mole game: fetches a pattern from the rng,
// lights it for a fixed window, scores switch hits and counts misses and
// wrong hits over NUM_ROUNDS rounds.
module mole_scheduler #(
    parameter int NUM_LEDS   = 18,
    parameter int TICK_DIV   = 50000,
    parameter int MOLE_TICKS = 1000,
    parameter int GAP_TICKS  = 250,
    parameter int NUM_ROUNDS = 30,
    parameter int RNG_WAIT   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [NUM_LEDS-1:0] rng_value,
    output logic                rng_change,
    input  logic [NUM_LEDS-1:0] switches,
    output logic [NUM_LEDS-1:0] leds,
    output logic [11:0]         score,
    output logic [11:0]         misses,
    output logic [11:0]         wrong_hits,
    output logic [7:0]          round_num,
    output logic                busy,
    output logic                game_over
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TMAX = (MOLE_TICKS > GAP_TICKS) ? MOLE_TICKS : GAP_TICKS;
    localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int WW = (RNG_WAIT > 1) ? $clog2(RNG_WAIT) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] MOLE_LAST  = TW'(MOLE_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_TICKS - 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(RNG_WAIT - 1);
    localparam logic [7:0]    LAST_ROUND = 8'(NUM_ROUNDS);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        LOAD = 3'd3,
        SHOW = 3'd4,
        GAP  = 3'd5,
        DONE = 3'd6
    } state_t;

    // Number of set bits, widened to the counter width
    function automatic logic [11:0] popcount(input logic [NUM_LEDS-1:0] v);
        logic [11:0] c;
        c = 12'd0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            c = c + {11'd0, v[i]};
        end
        return c;
    endfunction

    // Counter addition that sticks at 4095 instead of wrapping
    function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [11:0] b);
        logic [12:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[12] ? 12'hFFF : s[11:0];
    endfunction

    state_t              state_r, state_next_s;
    logic                start_prev_r;
    logic [NUM_LEDS-1:0] sw_prev_r;
    logic [PW-1:0]       presc_r, presc_next_s;
    logic [TW-1:0]       tick_cnt_r, tick_cnt_next_s;
    logic [WW-1:0]       wait_cnt_r, wait_cnt_next_s;

    logic [NUM_LEDS-1:0] leds_r, leds_next_s;
    logic [11:0]         score_r, score_next_s;
    logic [11:0]         misses_r, misses_next_s;
    logic [11:0]         wrong_r, wrong_next_s;
    logic [7:0]          round_r, round_next_s;
    logic                rng_change_r, busy_r, game_over_r;

    logic                start_edge_s;
    logic [NUM_LEDS-1:0] sw_edge_s, hit_s, wrong_hit_s, leds_after_s;
    logic                timed_s, tick_s, mole_expire_s, gap_expire_s;

    assign start_edge_s  = start & ~start_prev_r;
    assign sw_edge_s     = switches & ~sw_prev_r;
    assign hit_s         = sw_edge_s & leds_r;
    assign wrong_hit_s   = sw_edge_s & ~leds_r;
    assign leds_after_s  = leds_r & ~hit_s;
    assign timed_s       = (state_r == SHOW) || (state_r == GAP);
    assign tick_s        = timed_s && (presc_r == PRESC_LAST);
    assign mole_expire_s = tick_s && (tick_cnt_r == MOLE_LAST);
    assign gap_expire_s  = tick_s && (tick_cnt_r == GAP_LAST);

    // Next-state, counter and output computation for the round sequencer
    always_comb begin
        state_next_s  = state_r;
        leds_next_s   = leds_r;
        score_next_s  = score_r;
        misses_next_s = misses_r;
        wrong_next_s  = wrong_r;
        round_next_s  = round_r;
        case (state_r)
            IDLE, DONE: begin
                if (start_edge_s) begin
                    score_next_s  = 12'd0;
                    misses_next_s = 12'd0;
                    wrong_next_s  = 12'd0;
                    round_next_s  = 8'd1;
                    state_next_s  = REQ;
                end else begin
                    state_next_s = state_r;
                end
            end
            REQ: begin
                state_next_s = WAIT;
            end
            WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = WAIT;
                end
            end
            LOAD: begin
                if (rng_value == {NUM_LEDS{1'b0}}) begin
                    leds_next_s = {{(NUM_LEDS-1){1'b0}}, 1'b1};
                end else begin
                    leds_next_s = rng_value;
                end
                state_next_s = SHOW;
            end
            SHOW: begin
                score_next_s = sat_add(score_r, popcount(hit_s));
                wrong_next_s = sat_add(wrong_r, popcount(wrong_hit_s));
                if (leds_after_s == {NUM_LEDS{1'b0}}) begin
                    leds_next_s  = {NUM_LEDS{1'b0}};
                    state_next_s = GAP;
                end else if (mole_expire_s) begin
                    misses_next_s = sat_add(misses_r, popcount(leds_after_s));
                    leds_next_s   = {NUM_LEDS{1'b0}};
                    state_next_s  = GAP;
                end else begin
                    leds_next_s = leds_after_s;
                end
            end
            GAP: begin
                leds_next_s  = {NUM_LEDS{1'b0}};
                wrong_next_s = sat_add(wrong_r, popcount(sw_edge_s));
                if (gap_expire_s) begin
                    if (round_r == LAST_ROUND) begin
                        state_next_s = DONE;
                    end else begin
                        round_next_s = round_r + 8'd1;
                        state_next_s = REQ;
                    end
                end else begin
                    state_next_s = GAP;
                end
            end
            default: begin
                leds_next_s  = {NUM_LEDS{1'b0}};
                state_next_s = IDLE;
            end
        endcase

        // Prescaler and tick counter restart whenever a timed state is (re)entered
        if (timed_s && (state_next_s == state_r)) begin
            presc_next_s = tick_s ? {PW{1'b0}} : presc_r + {{(PW-1){1'b0}}, 1'b1};
            tick_cnt_next_s = tick_s ? tick_cnt_r + {{(TW-1){1'b0}}, 1'b1} : tick_cnt_r;
        end else begin
            presc_next_s    = {PW{1'b0}};
            tick_cnt_next_s = {TW{1'b0}};
        end

        if ((state_r == WAIT) && (state_next_s == WAIT)) begin
            wait_cnt_next_s = wait_cnt_r + {{(WW-1){1'b0}}, 1'b1};
        end else begin
            wait_cnt_next_s = {WW{1'b0}};
        end
    end

    // State, edge history, timers and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r      <= IDLE;
            start_prev_r <= 1'b0;
            sw_prev_r    <= {NUM_LEDS{1'b0}};
            presc_r      <= {PW{1'b0}};
            tick_cnt_r   <= {TW{1'b0}};
            wait_cnt_r   <= {WW{1'b0}};
            leds_r       <= {NUM_LEDS{1'b0}};
            score_r      <= 12'd0;
            misses_r     <= 12'd0;
            wrong_r      <= 12'd0;
            round_r      <= 8'd0;
            rng_change_r <= 1'b0;
            busy_r       <= 1'b0;
            game_over_r  <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            start_prev_r <= start;
            sw_prev_r    <= switches;
            presc_r      <= presc_next_s;
            tick_cnt_r   <= tick_cnt_next_s;
            wait_cnt_r   <= wait_cnt_next_s;
            leds_r       <= leds_next_s;
            score_r      <= score_next_s;
            misses_r     <= misses_next_s;
            wrong_r      <= wrong_next_s;
            round_r      <= round_next_s;
            rng_change_r <= (state_next_s == REQ);
            busy_r       <= (state_next_s != IDLE) && (state_next_s != DONE);
            game_over_r  <= (state_next_s == DONE);
        end
    end

    assign leds       = leds_r;
    assign score      = score_r;
    assign misses     = misses_r;
    assign wrong_hits = wrong_r;
    assign round_num  = round_r;
    assign rng_change = rng_change_r;
    assign busy       = busy_r;
    assign game_over  = game_over_r;

endmodule
